// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: synchronises the PLL locked flag and sequences the system reset of the PLL clock domain.
// Optional lock-loss status (lock_lost, loss_count) is built only when PLL_RESET_LOSS_CNT_EN is defined.
`default_nettype none

module pll_reset_ctrl #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             locked,
  input  logic             clear_lost,
  output logic             sys_reset_n,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_count
);

  localparam int MAX_CYC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   run_q;
  logic                   loss_event;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], locked};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_event = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end
      end
      STABILIZE: begin
        // Any drop, however short, forces a full requalification.
        if (!locked_s)                state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = RUN;
        else                          cnt_d   = cnt_q + 1'b1;
      end
      RUN: begin
        if (!locked_s) begin
          state_d    = HOLD;
          cnt_d      = '0;
          loss_event = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  assign sys_reset_n = run_q;
  assign ready       = run_q;

`ifdef PLL_RESET_LOSS_CNT_EN
  logic             lost_q;
  logic [CNT_W-1:0] count_q;

  // A loss event on the same edge as clear_lost takes priority and counts as the first loss.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lost_q  <= 1'b0;
      count_q <= '0;
    end else if (loss_event) begin
      lost_q  <= 1'b1;
      if (clear_lost)   count_q <= CNT_W'(1);
      else if (!(&count_q)) count_q <= count_q + 1'b1;
    end else if (clear_lost) begin
      lost_q  <= 1'b0;
      count_q <= '0;
    end
  end

  assign lock_lost  = lost_q;
  assign loss_count = count_q;
`else
  logic unused_status;
  assign unused_status = clear_lost ^ loss_event;
  assign lock_lost     = 1'b0;
  assign loss_count    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: randomized scoreboard bench; a cycle-level reference model predicts every output per edge.
`default_nettype none

module tb_pll_reset_ctrl;

  localparam int S      = 2;
  localparam int STABLE = 8;
  localparam int HOLD   = 4;
  localparam int CW     = 2;
  localparam int SAT    = (1 << CW) - 1;
`ifdef PLL_RESET_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          locked = 1'b0;
  logic          clear_lost = 1'b0;
  logic          sys_reset_n, ready, lock_lost;
  logic [CW-1:0] loss_count;

  pll_reset_ctrl #(
    .SYNC_STAGES(S), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .locked(locked), .clear_lost(clear_lost),
    .sys_reset_n(sys_reset_n), .ready(ready), .lock_lost(lock_lost), .loss_count(loss_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int rst_n;
    int rdy;
    int lost;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: locked as seen S edges late, a high-streak qualifier and a hold window.
  bit m_hist[S];
  int m_streak, m_hold_left, m_cnt;
  bit m_run, m_lost;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < S; i++) m_hist[i] = 1'b0;
    m_streak = 0; m_hold_left = 0; m_cnt = 0;
    m_run = 1'b0; m_lost = 1'b0;
  endfunction

  function automatic void model_step(input bit lk, input bit clr);
    bit   ls;
    bit   ev;
    exp_t e;
    ev = 1'b0;
    if (!reset_n) begin
      model_reset();
    end else begin
      ls = m_hist[S-1];
      for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = lk;
      if (m_run) begin
        if (!ls) begin
          m_run = 1'b0; m_hold_left = HOLD; m_streak = 0; ev = 1'b1;
        end
      end else if (m_hold_left > 0) begin
        m_hold_left--;
      end else begin
        m_streak = ls ? m_streak + 1 : 0;
        if (m_streak == STABLE + 1) begin
          m_run = 1'b1; m_streak = 0;
        end
      end
      if (CNT_EN) begin
        if (clr) begin m_lost = 1'b0; m_cnt = 0; end
        if (ev) begin
          m_lost = 1'b1;
          m_cnt  = clr ? 1 : ((m_cnt == SAT) ? SAT : m_cnt + 1);
        end
      end
    end
    e.rst_n = m_run; e.rdy = m_run; e.lost = m_lost; e.cnt = m_cnt;
    exp_q.push_back(e);
  endfunction

  task automatic drive_r(input bit lk, input bit clr, input bit rn);
    @(negedge clock);
    reset_n    = rn;
    locked     = lk;
    clear_lost = clr;
    model_step(lk, clr);
  endtask

  task automatic drive(input bit lk, input bit clr);
    drive_r(lk, clr, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sys_reset_n"}, int'(sys_reset_n), 0);
    check({tag, "_ready"},       int'(ready), 0);
    check({tag, "_lock_lost"},   int'(lock_lost), 0);
    check({tag, "_loss_count"},  int'(loss_count), 0);
  endtask

  // Asserts reset_n between clock edges and checks that outputs drop without waiting for an edge.
  task automatic async_reset(input string tag);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
  endtask

  task automatic qualify();
    int n;
    n = 0;
    while (!m_run && n < 100) begin
      drive(1'b1, 1'b0);
      n++;
    end
    check("qualify_within_budget", int'(m_run), 1);
  endtask

  // Drops locked from RUN; clr_on_event pulses clear_lost on the RUN->HOLD edge.
  task automatic lose(input bit clr_on_event);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, clr_on_event);
    drive(1'b1, 1'b0);
  endtask

  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("sys_reset_n", int'(sys_reset_n), mon_e.rst_n);
      check("ready",       int'(ready),       mon_e.rdy);
      check("lock_lost",   int'(lock_lost),   mon_e.lost);
      check("loss_count",  int'(loss_count),  mon_e.cnt);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    bit lvl;
    model_reset();
    locked = 1'b1;
    #1;
    check_zero("reset_state");
    repeat (3) drive_r(1'b1, 1'b0, 1'b0);

    // Release with locked already high, then sit in RUN.
    repeat (14) drive(1'b1, 1'b0);

    // Glitch during qualification.
    async_reset("reset_mid_run");
    drive_r(1'b1, 1'b0, 1'b0);
    repeat (6) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    repeat (12) drive(1'b1, 1'b0);

    // Single loss with locked returning immediately.
    lose(1'b0);
    qualify();

    // Saturate the loss counter, then clear on the same edge as another loss.
    for (int i = 0; i < 5; i++) begin
      lose(1'b0);
      qualify();
    end
    lose(1'b1);
    qualify();
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);

    // Async reset mid-HOLD and mid-STABILIZE.
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    async_reset("reset_mid_hold");
    drive_r(1'b1, 1'b0, 1'b0);
    repeat (5) drive(1'b1, 1'b0);
    async_reset("reset_mid_stabilize");
    drive_r(1'b1, 1'b0, 1'b0);
    repeat (14) drive(1'b1, 1'b0);

    // Randomized phase: mostly long stable periods, some short glitches, sporadic clears and resets.
    lvl = 1'b1;
    for (int blk = 0; blk < 200; blk++) begin
      lvl = ~lvl;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 20);
      for (int c = 0; c < len; c++) drive(lvl, ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 40) == 0) begin
        async_reset("reset_random");
        repeat ($urandom_range(1, 3)) drive_r(1'b1, 1'b0, 1'b0);
      end
    end

    repeat (3) drive(1'b1, 1'b0);
    @(posedge clock);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
